// File: rtl/asteroid_spawn_if.sv
// Control and feedback bundle between the spawn scheduler
// and the asteroid mover.
interface asteroid_spawn_if;
    logic       halt;
    logic       start;
    logic [9:0] xmovaddr;
    logic       asteroid_on;
    logic [7:0] spawn_count;
    logic       busy;

    modport master (
        input  halt,
        input  start,
        input  xmovaddr,
        output asteroid_on,
        output spawn_count,
        output busy
    );

    modport slave (
        output halt,
        output start,
        output xmovaddr,
        input  asteroid_on,
        input  spawn_count,
        input  busy
    );
endinterface

// File: rtl/asteroid_spawn.sv
// Asteroid spawn scheduler: raises asteroid_on, waits for the
// mover to leave the screen, then waits a random tick gap.
module asteroid_spawn #(
    parameter int          TICK_DIV   = 251250,
    parameter int          MIN_GAP    = 60,
    parameter logic [7:0]  GAP_MASK   = 8'h7F,
    parameter logic [9:0]  TRAVEL_LEN = 10'd700,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    asteroid_spawn_if.master bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [8:0] GAP_BASE = 9'(MIN_GAP);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_ACTIVE,
        S_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [8:0]    gap_cnt_q, gap_cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          on_q, on_d;
    logic [7:0]    count_q, count_d;
    logic          busy_q, busy_d;
    logic [8:0]    gap_load;

    assign gap_load = GAP_BASE + {1'b0, lfsr_q[7:0] & GAP_MASK};

    // Next-state, counters and LFSR; halt freezes everything.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        lfsr_d     = lfsr_q;
        on_d       = on_q;
        count_d    = count_q;
        if (!bus.halt) begin
            if (lfsr_q == 16'h0) begin
                lfsr_d = LFSR_SEED;
            end else if (lfsr_q[0]) begin
                lfsr_d = {1'b0, lfsr_q[15:1]} ^ LFSR_TAPS;
            end else begin
                lfsr_d = {1'b0, lfsr_q[15:1]};
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d    = S_GAP;
                        gap_cnt_d  = gap_load;
                        tick_cnt_d = '0;
                    end
                end
                S_GAP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        gap_cnt_d  = gap_cnt_q - 9'd1;
                        if (gap_cnt_q == 9'd1) begin
                            state_d = S_ACTIVE;
                            on_d    = 1'b1;
                            if (count_q != 8'hFF) begin
                                count_d = count_q + 8'd1;
                            end
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (bus.xmovaddr >= TRAVEL_LEN) begin
                        state_d = S_CLEAR;
                        on_d    = 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_d    = S_GAP;
                    gap_cnt_d  = gap_load;
                    tick_cnt_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    on_d    = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            gap_cnt_q  <= '0;
            lfsr_q     <= LFSR_SEED;
            on_q       <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            lfsr_q     <= lfsr_d;
            on_q       <= on_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.asteroid_on = on_q;
    assign bus.spawn_count = count_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_asteroid_spawn.sv
// Bench for asteroid_spawn: directed timing checks on a fixed-gap
// instance, random run against a reference gap model on a second one.
module tb_asteroid_spawn;

    localparam int TD = 4;
    localparam int MG = 2;
    localparam logic [9:0] TL = 10'd5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst1_n = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    asteroid_spawn_if b0();
    asteroid_spawn_if b1();

    asteroid_spawn #(
        .TICK_DIV(TD), .MIN_GAP(MG), .GAP_MASK(8'h00),
        .TRAVEL_LEN(TL), .LFSR_SEED(SEED)
    ) dut0 (
        .clk(clk), .reset(rst_n), .bus(b0)
    );

    asteroid_spawn #(
        .TICK_DIV(TD), .MIN_GAP(MG), .GAP_MASK(8'h03),
        .TRAVEL_LEN(TL), .LFSR_SEED(SEED)
    ) dut1 (
        .clk(clk), .reset(rst1_n), .bus(b1)
    );

    // reference model state for dut1
    logic [15:0] ref_lfsr = SEED;
    bit pend_load = 0;
    bit mark_valid = 0;
    bit in_active = 0;
    bit exit_due = 0;
    bit prev_on1 = 0;
    int mark = 0;
    int extra = 0;
    int halts = 0;
    int exp_g = 0;
    int n_spawn = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v == 16'h0) return SEED;
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic monitor1();
        int elapsed;
        if (in_active) begin
            chk("exit_timing", b1.asteroid_on, !exit_due);
            if (!b1.asteroid_on) begin
                in_active = 0;
                exit_due = 0;
                pend_load = 1;
                mark = cyc;
                extra = 1;
                halts = 0;
                mark_valid = 1;
            end
        end else if (b1.asteroid_on && !prev_on1) begin
            n_spawn++;
            elapsed = cyc - mark - extra - halts;
            chk("gap_cycles", elapsed, exp_g * TD);
            chk("gap_range", (elapsed >= 2 * TD && elapsed <= 5 * TD), 1);
            chk("spawn_count", b1.spawn_count,
                (n_spawn > 255) ? 255 : n_spawn);
            in_active = 1;
            exit_due = 0;
            mark_valid = 0;
        end
        prev_on1 = b1.asteroid_on;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst1_n) begin
            if (!b1.halt) begin
                if (pend_load) begin
                    exp_g = MG + int'(ref_lfsr[7:0] & 8'h03);
                    pend_load = 0;
                end
                ref_lfsr = lfsr_next(ref_lfsr);
                if (in_active && b1.xmovaddr >= TL) exit_due = 1;
            end else if (mark_valid) begin
                halts++;
            end
        end
        #1;
        if (rst1_n) monitor1();
    endtask

    initial begin
        int bad;
        int s;
        int guard;
        b0.halt = 0; b0.start = 0; b0.xmovaddr = '0;
        b1.halt = 0; b1.start = 0; b1.xmovaddr = '0;

        // reset values and idle
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_on", b0.asteroid_on, 0);
        chk("rst_count", b0.spawn_count, 0);
        chk("rst_busy", b0.busy, 0);
        bad = 0;
        repeat (100) begin
            step();
            if (b0.asteroid_on || b0.busy) bad++;
        end
        chk("idle_100", bad, 0);

        // start ignored while halted
        b0.halt = 1; b0.start = 1;
        step();
        b0.halt = 0; b0.start = 0;
        step();
        chk("halt_blocks_start", b0.busy, 0);

        // start latency
        cyc = 0;
        while (cyc < 9) step();
        b0.start = 1;
        step();
        b0.start = 0;
        chk("start_busy", b0.busy, 1);
        while (cyc < 17) step();
        chk("pre_rise17", b0.asteroid_on, 0);
        step();
        chk("rise18", b0.asteroid_on, 1);
        chk("count1", b0.spawn_count, 1);

        // exit and respawn
        while (cyc < 29) step();
        b0.xmovaddr = 10'd5;
        step();
        chk("exit30", b0.asteroid_on, 0);
        chk("exit30_busy", b0.busy, 1);
        b0.xmovaddr = 10'd0;
        while (cyc < 38) step();
        chk("pre_rise38", b0.asteroid_on, 0);
        step();
        chk("rise39", b0.asteroid_on, 1);
        chk("count2", b0.spawn_count, 2);

        // halt mid-gap delays the rise by 10 cycles
        while (cyc < 44) step();
        b0.xmovaddr = 10'd5;
        step();
        chk("exit45", b0.asteroid_on, 0);
        b0.xmovaddr = 10'd0;
        while (cyc < 47) step();
        b0.halt = 1;
        repeat (10) step();
        b0.halt = 0;
        while (cyc < 63) step();
        chk("halt_pre63", b0.asteroid_on, 0);
        step();
        chk("halt_rise64", b0.asteroid_on, 1);
        chk("count3", b0.spawn_count, 3);

        // halt in active overrides the threshold
        while (cyc < 66) step();
        b0.halt = 1;
        b0.xmovaddr = 10'd5;
        bad = 0;
        repeat (5) begin
            step();
            if (!b0.asteroid_on) bad++;
        end
        chk("halt_hold_on", bad, 0);
        b0.halt = 0;
        step();
        chk("halt_exit72", b0.asteroid_on, 0);
        b0.xmovaddr = 10'd0;
        while (cyc < 80) step();
        chk("pre_rise80", b0.asteroid_on, 0);
        step();
        chk("rise81", b0.asteroid_on, 1);
        chk("count4", b0.spawn_count, 4);

        // asynchronous reset mid-active
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_on", b0.asteroid_on, 0);
        chk("arst_count", b0.spawn_count, 0);
        chk("arst_busy", b0.busy, 0);
        step();
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            step();
            if (b0.asteroid_on || b0.busy) bad++;
        end
        chk("arst_stays_idle", bad, 0);
        b0.start = 1;
        step();
        b0.start = 0;
        s = cyc;
        while (cyc < s + 7) step();
        chk("arst_pre_rise", b0.asteroid_on, 0);
        step();
        chk("arst_rise", b0.asteroid_on, 1);
        chk("arst_count1", b0.spawn_count, 1);

        // random gaps, halts and exits on dut1
        rst1_n = 1'b1;
        ref_lfsr = SEED;
        repeat (7) step();
        b1.start = 1;
        mark = cyc + 1;
        extra = 0;
        halts = 0;
        pend_load = 1;
        mark_valid = 1;
        step();
        b1.start = 0;
        chk("rand_busy", b1.busy, 1);
        guard = 0;
        while (n_spawn < 300 && guard < 40000) begin
            b1.halt = ($urandom_range(0, 19) == 0);
            if (in_active) begin
                if ($urandom_range(0, 3) == 0)
                    b1.xmovaddr = 10'($urandom_range(5, 1023));
                else
                    b1.xmovaddr = 10'($urandom_range(0, 4));
            end else begin
                b1.xmovaddr = 10'd0;
            end
            step();
            guard++;
        end
        chk("rand_spawns", n_spawn, 300);
        chk("sat_count", b1.spawn_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asteroid_spawn.md
# asteroid_spawn

Upstream scheduler for the asteroid mover. Decides when an asteroid enters the playfield by driving `asteroid_on`. Holds it high while the mover advances the asteroid, drops it once the mover's x offset shows the asteroid has left the screen, then waits a pseudo-random number of movement ticks before the next spawn. Shares the mover's tick period, so gaps are measured in the same units as asteroid motion.

## Interface
- `TICK_DIV`, 251250: clocks per movement tick; must match the mover's step period; ≥2.
- `MIN_GAP`, 60: minimum gap between asteroids, in ticks; ≥1.
- `GAP_MASK`, 8'h7F: mask applied to LFSR low byte; random extra gap = `lfsr[7:0] & GAP_MASK` ticks.
- `TRAVEL_LEN`, 10'd700: x offset at or beyond which the asteroid counts as off-screen.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `halt`, in, 1: game-over/pause freeze; high freezes all state.
- `start`, in, 1: single-cycle pulse that begins spawning from IDLE.
- `xmovaddr`, in, 10: mover's current x offset (feedback).
- `asteroid_on`, out, 1: registered spawn enable to the mover.
- `spawn_count`, out, 8: number of asteroids spawned since reset; saturates at 255.
- `busy`, out, 1: high in any state except IDLE.

## Operation
- **Reset (reset low, immediate, asynchronous):**
  - state=IDLE, `asteroid_on`=0, `spawn_count`=0, `busy`=0.
  - `tick_cnt`=0, `gap_cnt`=0, `lfsr`=`LFSR_SEED`.
- **LFSR:**
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every clock while `halt`=0, in every state.
  - If it ever reads 0, it reloads `LFSR_SEED` on the next clock.
- **States:**
  - **IDLE:** `asteroid_on`=0. `start`=1 with `halt`=0 moves to GAP and loads the gap. `start` is ignored in all other states.
  - **GAP:** `asteroid_on`=0.
    - `tick_cnt` counts 0..`TICK_DIV`-1 and wraps; a tick is the cycle where `tick_cnt`=`TICK_DIV`-1.
    - Each tick decrements `gap_cnt`.
    - A tick with `gap_cnt`=1 moves to ACTIVE, sets `asteroid_on`=1, and increments `spawn_count` (saturating).
  - **ACTIVE:** `asteroid_on`=1. When `xmovaddr` ≥ `TRAVEL_LEN`, move to CLEAR and set `asteroid_on`=0.
  - **CLEAR:** one cycle with `asteroid_on`=0, which lets the mover zero its offsets. Then move to GAP and load a fresh gap.
- **Gap load (on entry to GAP):**
  - `gap_cnt` = `MIN_GAP` + (`lfsr[7:0]` & `GAP_MASK`), computed at 9 bits with no overflow.
  - `lfsr` is sampled on the same edge that enters GAP.
  - `tick_cnt` is cleared to 0.
- **Halt:**
  - `halt`=1 freezes state, all counters, the LFSR and `spawn_count`.
  - `asteroid_on` holds its current value.
  - Halt takes priority over every transition, including the `xmovaddr` threshold and `start`.
- **Reset mid-operation:** returns to IDLE with no spawn; a new `start` is required.

## Timing
- All outputs are registered and change only on a `clk` rising edge, except on asynchronous reset.
- `start` sampled at edge k: state=GAP after edge k. With no halt, `asteroid_on` rises after edge k + G·`TICK_DIV`, where G is the loaded gap.
- Threshold seen at edge m (`xmovaddr` ≥ `TRAVEL_LEN` while in ACTIVE): `asteroid_on`=0 after edge m. CLEAR lasts for edge m+1. GAP is entered at edge m+1, and the next rise comes G·`TICK_DIV` cycles after that.
- The minimum `asteroid_on` low time between asteroids is 1 + `MIN_GAP`·`TICK_DIV` cycles.
- Each halted cycle delays every pending event by exactly one cycle.
- `busy` = (state ≠ IDLE), registered together with state.

## Test plan
Bench parameters: `TICK_DIV`=4, `MIN_GAP`=2, `GAP_MASK`=0, `TRAVEL_LEN`=5, unless a line says otherwise.

- **Reset values:** hold reset low, then release → `asteroid_on`=0, `spawn_count`=0, `busy`=0; stays idle for 100 cycles with no `start`.
- **Start latency:** `start` pulse at edge 10 → `busy`=1 after edge 10; `asteroid_on`=1 after edge 18; `spawn_count`=1.
- **Exit and respawn:** drive `xmovaddr`=5 at edge 30 → `asteroid_on`=0 after edge 30; it rises again after edge 39; `spawn_count`=2.
- **Halt:** raise `halt` for 10 cycles mid-GAP → rise delayed by exactly 10 cycles. Raise `halt` in ACTIVE with `xmovaddr`=5 → `asteroid_on` stays 1 until `halt` drops.
- **Asynchronous reset:** pull reset low mid-ACTIVE, between clock edges → `asteroid_on`=0 and `spawn_count`=0 immediately. A `start` is then required to spawn again.
- **Random gaps and saturation:** set `GAP_MASK`=8'h03 and run 300 spawns → every gap lies in [2,5] ticks and matches a reference LFSR model; `spawn_count` holds at 255.
